// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus an optional
// radix-2 shift-add multiplier that takes WIDTH cycles.
module seq_alu #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] data_j,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             eq,
  output logic             lt,
  output logic             carry
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  typedef enum logic [2:0] {
    OP_PASS = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
    OP_OR   = 3'd4, OP_NOT = 3'd5, OP_CMP = 3'd6, OP_MUL = 3'd7
  } op_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_eq_p;
  logic               r_lt_p;
  logic [WIDTH-1:0]   r_result;
  logic               r_eq;
  logic               r_lt;
  logic               r_carry;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_mul_go;

  always_comb begin
    w_sum   = {1'b0, data_i} + {1'b0, data_j};
    w_res   = '0;
    w_carry = 1'b0;
    case (op_t'(op))
      OP_PASS: w_res = data_j;
      OP_ADD:  begin w_res = w_sum[WIDTH-1:0]; w_carry = w_sum[WIDTH]; end
      OP_SUB:  begin w_res = data_i - data_j; w_carry = (data_i < data_j); end
      OP_AND:  w_res = data_i & data_j;
      OP_OR:   w_res = data_i | data_j;
      OP_NOT:  w_res = ~data_j;
      OP_CMP:  w_res = '0;
      OP_MUL:  w_res = '0;  // only reached when the multiplier is absent
      default: w_res = '0;
    endcase
    w_mul_go   = start && (op == OP_MUL) && (MUL_EN != 0);
    // The final partial product is folded in combinationally so the
    // completing edge can register the full product directly.
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_eq_p   <= 1'b0;
      r_lt_p   <= 1'b0;
      r_result <= '0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mul_go) begin
            r_mcand  <= {{WIDTH{1'b0}}, data_i};
            r_mplier <= data_j;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
            r_eq_p   <= (data_i == data_j);
            r_lt_p   <= (data_i < data_j);
            r_busy   <= 1'b1;
            r_state  <= S_MUL;
          end else if (start) begin
            r_result <= w_res;
            r_carry  <= w_carry;
            r_eq     <= (data_i == data_j);
            r_lt     <= (data_i < data_j);
            r_done   <= 1'b1;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result <= w_acc_next[WIDTH-1:0];
            r_carry  <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_eq     <= r_eq_p;
            r_lt     <= r_lt_p;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign eq     = r_eq;
  assign lt     = r_lt;
  assign carry  = r_carry;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboarded bench for seq_alu: directed corner cases then randomized ops
// checked against an arithmetic reference model.
module tb_seq_alu;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] data_i;
  logic [W-1:0] data_j;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         eq;
  logic         lt;
  logic         carry;

  seq_alu #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .data_i(data_i), .data_j(data_j),
    .busy(busy), .done(done), .result(result),
    .eq(eq), .lt(lt), .carry(carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] res;
    logic         eq;
    logic         lt;
    logic         carry;
  } exp_t;

  exp_t        q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input bit ok, input string name, input string detail);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint unsigned A, B, M, s;
    A = a; B = b; M = 64'd1 << W;
    e.op = o; e.eq = (A == B); e.lt = (A < B); e.carry = 1'b0; e.res = '0;
    case (o)
      3'd0: e.res = b;
      3'd1: begin s = A + B;     e.res = W'(s % M); e.carry = (s >= M); end
      3'd2: begin s = A + M - B; e.res = W'(s % M); e.carry = (A < B); end
      3'd3: e.res = a & b;
      3'd4: e.res = a | b;
      3'd5: e.res = W'((M - 1) - B);
      3'd6: e.res = '0;
      3'd7: begin s = A * B;     e.res = W'(s % M); e.carry = (s >= M); end
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // Monitor: pops on every done, otherwise outputs must hold.
  initial begin
    exp_t         e;
    logic [W-1:0] l_res;
    logic         l_eq, l_lt, l_c;
    l_res = '0; l_eq = 1'b0; l_lt = 1'b0; l_c = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        l_res = '0; l_eq = 1'b0; l_lt = 1'b0; l_c = 1'b0;
      end else if (done) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_done",
                $sformatf("got done with result=%h but nothing pending, want no done", result));
        end else begin
          e = q.pop_front();
          check({result, eq, lt, carry} === {e.res, e.eq, e.lt, e.carry}, $sformatf("op%0d", e.op),
                $sformatf("got res=%h eq=%b lt=%b c=%b, want res=%h eq=%b lt=%b c=%b",
                          result, eq, lt, carry, e.res, e.eq, e.lt, e.carry));
        end
        l_res = result; l_eq = eq; l_lt = lt; l_c = carry;
      end else begin
        check({result, eq, lt, carry} === {l_res, l_eq, l_lt, l_c}, "hold",
              $sformatf("got res=%h eq=%b lt=%b c=%b, want res=%h eq=%b lt=%b c=%b",
                        result, eq, lt, carry, l_res, l_eq, l_lt, l_c));
      end
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; data_i = a; data_j = b;
    q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0;
    check(done === 1'b1 && busy === 1'b0, "lat1",
          $sformatf("op%0d done=%b busy=%b, want done=1 busy=0", o, done, busy));
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit junk);
    int unsigned nb, lat;
    bit          found;
    start = 1'b1; op = 3'd7; data_i = a; data_j = b;
    q.push_back(model(3'd7, a, b));
    @(negedge clk);
    nb = 0; lat = 0; found = 1'b0;
    for (int k = 1; k <= int'(W) + 8; k++) begin
      if (done === 1'b1) begin found = 1'b1; lat = k - 1; break; end
      if (busy === 1'b1) nb++;
      if (junk) begin
        start = 1'b1; op = 3'd1; data_i = W'($urandom); data_j = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check(found, "mul_done", $sformatf("done seen=%b, want 1", found));
    check(lat == W, "mul_lat", $sformatf("latency=%0d, want %0d", lat, W));
    check(nb == W, "mul_busy", $sformatf("busy cycles=%0d, want %0d", nb, W));
  endtask

  task automatic check_zero(input string name);
    check({result, eq, lt, carry, busy, done} === '0, name,
          $sformatf("got res=%h eq=%b lt=%b c=%b busy=%b done=%b, want all 0",
                    result, eq, lt, carry, busy, done));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]   o;
    logic [W-1:0] a, b;
    rst = 1'b1; start = 1'b0; op = 3'd0; data_i = '0; data_j = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd1, 16'hFFFF, 16'h0001);
    run_op(3'd2, 16'h0003, 16'h0005);
    run_op(3'd5, 16'h0000, 16'h00F0);
    run_mul(16'h0012, 16'h0034, 1'b0);
    run_mul(16'h0100, 16'h0100, 1'b1);

    // Abort a multiply mid-flight: pending result must never appear.
    start = 1'b1; op = 3'd7; data_i = 16'h1234; data_j = 16'h5678;
    q.push_back(model(3'd7, 16'h1234, 16'h5678));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check(busy === 1'b1, "abort_busy", $sformatf("busy=%b, want 1", busy));
    rst = 1'b1;
    q.delete();
    #1;
    check_zero("rst_clear");
    @(negedge clk);
    check_zero("rst_hold");
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    run_op(3'd6, 16'h1234, 16'h1234);

    run_op(3'd1, 16'h1111, 16'h2222);
    run_op(3'd4, 16'hA050, 16'h0A05);
    run_op(3'd3, 16'hF0F0, 16'h3C3C);
    run_mul(16'hFFFF, 16'hFFFF, 1'b0);
    run_mul(16'h0000, 16'hBEEF, 1'b0);

    for (int n = 0; n < 80; n++) begin
      o = 3'($urandom_range(0, 7));
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = W'($urandom_range(0, 15));
        default: b = W'($urandom);
      endcase
      if (o == 3'd7) run_mul(a, b, 1'($urandom_range(0, 1)));
      else           run_op(o, a, b);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check(q.size() == 0, "drain", $sformatf("pending=%0d, want 0", q.size()));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
